// File: rtl/step_sequencer_ctrl_pkg.sv
// rtl/step_sequencer_ctrl_pkg.sv - shared state encoding, count width and Gray helper
package step_sequencer_ctrl_pkg;

   localparam int CNT_W = 3;
   localparam int REM_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/seq3_core.sv
// rtl/seq3_core.sv - 3-bit up/down sequence register with binary/Gray output encoding
module seq3_core
   import step_sequencer_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             adv_i,
   input  logic             dir_i,
   input  logic             gray_sel_i,
   output logic [CNT_W-1:0] abc_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // One modulo-8 step per advance; the count only ever returns to zero through reset or wrap
   always_comb begin
      count_d = count_q;
      if (adv_i) begin
         count_d = dir_i ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign abc_o = gray_sel_i ? bin2gray(count_q) : count_q;

endmodule

// File: rtl/step_sequencer_ctrl.sv
// rtl/step_sequencer_ctrl.sv - run/pause/step sequencer FSM; optional PRESCALE_EN run-tick prescaler
module step_sequencer_ctrl
   import step_sequencer_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       STOP,
   input  logic       STEP,
   input  logic       DIR,
   input  logic [2:0] LEN,
   input  logic       GRAY_SEL,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       BUSY,
   output logic       DONE,
   output logic [1:0] STATE
);

   if (TICK_DIV < 2 || TICK_DIV > 16) begin : g_tick_div_check
      $error("step_sequencer_ctrl: TICK_DIV must be within 2..16");
   end

   state_e           state_q;
   state_e           state_d;
   logic [REM_W-1:0] rem_q;
   logic [REM_W-1:0] rem_d;
   logic             adv;
   logic             tick;
   logic [CNT_W-1:0] abc;

`ifdef PRESCALE_EN
   logic [3:0] presc_q;
   logic [3:0] presc_d;

   assign tick = (presc_q == 4'(TICK_DIV - 1));

   // Prescaler only runs while in RUN; any other state, or a STOP being taken, holds it at zero
   always_comb begin
      presc_d = presc_q + 4'd1;
      if (state_q != ST_RUN || STOP || tick) begin
         presc_d = '0;
      end
   end

   // Prescaler register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Next-state, remaining-step bookkeeping and advance request; STOP beats START beats STEP
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      adv     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!STOP) begin
               if (START) begin
                  state_d = ST_RUN;
                  rem_d   = (LEN == 3'd0) ? REM_W'(8) : {1'b0, LEN};
               end else if (STEP) begin
                  adv = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (STOP) begin
               state_d = ST_PAUSE;
            end else if (tick) begin
               adv   = 1'b1;
               rem_d = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_PAUSE: begin
            if (STOP) begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end else if (START) begin
               state_d = ST_RUN;
            end else if (STEP) begin
               adv   = 1'b1;
               rem_d = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and remaining-step registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   seq3_core u_core (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .adv_i      (adv),
      .dir_i      (DIR),
      .gray_sel_i (GRAY_SEL),
      .abc_o      (abc)
   );

   assign {A, B, C} = abc;
   assign BUSY      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign DONE      = (state_q == ST_FIN);
   assign STATE     = state_q;

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// tb/tb_step_sequencer_ctrl.sv - scoreboard bench for step_sequencer_ctrl
module tb_step_sequencer_ctrl;

   logic       CLK;
   logic       RESET;
   logic       START;
   logic       STOP;
   logic       STEP;
   logic       DIR;
   logic [2:0] LEN;
   logic       GRAY_SEL;
   logic       A;
   logic       B;
   logic       C;
   logic       BUSY;
   logic       DONE;
   logic [1:0] STATE;

   int         n_vec;
   int         n_err;
   logic [6:0] sb[$];

   step_sequencer_ctrl dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .STOP     (STOP),
      .STEP     (STEP),
      .DIR      (DIR),
      .LEN      (LEN),
      .GRAY_SEL (GRAY_SEL),
      .A        (A),
      .B        (B),
      .C        (C),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .STATE    (STATE)
   );

   initial begin
      CLK = 1'b1;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got no finish, want finish");
      $fatal(1);
   end

   // Row layout: {start,stop,step, dir, len[2:0], gray, exp_abc[2:0], exp_done, exp_state[1:0], exp_busy}
   task automatic apply(input logic [14:0] r);
      @(negedge CLK);
      {START, STOP, STEP, DIR, LEN, GRAY_SEL} = r[14:7];
      sb.push_back(r[6:0]);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] got, e;
      RESET = 1'b1;
      START = 1'b1; STOP = 1'b0; STEP = 1'b1; DIR = 1'b1; LEN = 3'd3; GRAY_SEL = 1'b0;
      sb.push_back(7'b000_0_00_0);
      @(posedge CLK);
      #1;
      got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
      if (got !== e) begin
         n_err++; $display("FAIL reset_state got=%b want=%b", got, e);
      end
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      START = 1'b0; STEP = 1'b0;
   endtask

   task automatic test_basic_run();
      logic [14:0] t[$];
      logic [6:0]  got, e;
      t.push_back(15'b100_1_011_0_000_0_01_1);
      t.push_back(15'b000_1_111_0_001_0_01_1);
      t.push_back(15'b000_1_111_0_010_0_01_1);
      t.push_back(15'b000_1_111_0_011_1_11_0);
      t.push_back(15'b000_1_111_0_011_0_00_0);
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
         if (got !== e) begin
            n_err++; $display("FAIL basic_run[%0d] got=%b want=%b", i, got, e);
         end
      end
   endtask

   task automatic test_wrap();
      logic [14:0] t[$];
      logic [6:0]  got, e;
      t.push_back(15'b001_1_000_0_100_0_00_0);
      t.push_back(15'b001_1_000_0_101_0_00_0);
      t.push_back(15'b001_1_000_0_110_0_00_0);
      t.push_back(15'b001_1_000_0_111_0_00_0);
      t.push_back(15'b100_1_010_0_111_0_01_1);
      t.push_back(15'b000_1_010_0_000_0_01_1);
      t.push_back(15'b000_1_010_0_001_1_11_0);
      t.push_back(15'b000_1_010_0_001_0_00_0);
      t.push_back(15'b001_1_000_0_010_0_00_0);
      t.push_back(15'b001_1_000_0_011_0_00_0);
      t.push_back(15'b001_1_000_0_100_0_00_0);
      t.push_back(15'b001_1_000_0_101_0_00_0);
      t.push_back(15'b001_1_000_0_110_0_00_0);
      t.push_back(15'b001_1_000_0_111_0_00_0);
      t.push_back(15'b001_1_000_0_000_0_00_0);
      t.push_back(15'b100_0_010_0_000_0_01_1);
      t.push_back(15'b000_0_010_0_111_0_01_1);
      t.push_back(15'b000_0_010_0_110_1_11_0);
      t.push_back(15'b000_0_010_0_110_0_00_0);
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
         if (got !== e) begin
            n_err++; $display("FAIL wrap[%0d] got=%b want=%b", i, got, e);
         end
      end
   endtask

   task automatic test_gray_len8();
      logic [14:0] t[$];
      logic [6:0]  got, e;
      logic [23:0] gseq;
      gseq = {3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      t.push_back(15'b001_1_000_0_111_0_00_0);
      t.push_back(15'b001_1_000_0_000_0_00_0);
      t.push_back(15'b100_1_000_1_000_0_01_1);
      for (int k = 0; k < 7; k++) begin
         t.push_back({8'b000_1_000_1, gseq[23-3*k -: 3], 4'b0_01_1});
      end
      t.push_back({8'b000_1_000_1, gseq[2:0], 4'b1_11_0});
      t.push_back(15'b000_1_000_1_000_0_00_0);
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
         if (got !== e) begin
            n_err++; $display("FAIL gray_len8[%0d] got=%b want=%b", i, got, e);
         end
      end
   endtask

   task automatic test_pause_resume();
      logic [14:0] t[$];
      logic [6:0]  got, e;
      t.push_back(15'b100_1_101_0_000_0_01_1);
      t.push_back(15'b000_1_101_0_001_0_01_1);
      t.push_back(15'b000_1_101_0_010_0_01_1);
      t.push_back(15'b010_1_101_0_010_0_10_1);
      t.push_back(15'b000_1_101_0_010_0_10_1);
      t.push_back(15'b001_1_101_0_011_0_10_1);
      t.push_back(15'b100_1_101_0_011_0_01_1);
      t.push_back(15'b000_1_101_0_100_0_01_1);
      t.push_back(15'b000_1_101_0_101_1_11_0);
      t.push_back(15'b000_1_101_0_101_0_00_0);
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
         if (got !== e) begin
            n_err++; $display("FAIL pause_resume[%0d] got=%b want=%b", i, got, e);
         end
      end
   endtask

   task automatic test_priority_and_reset();
      logic [14:0] t[$];
      logic [6:0]  got, e;
      t.push_back(15'b110_1_101_0_101_0_00_0);
      t.push_back(15'b011_1_101_0_101_0_00_0);
      t.push_back(15'b101_1_101_0_101_0_01_1);
      t.push_back(15'b000_1_101_0_110_0_01_1);
      t.push_back(15'b110_1_101_0_110_0_10_1);
      t.push_back(15'b010_1_101_0_110_0_00_0);
      t.push_back(15'b001_0_101_0_101_0_00_0);
      t.push_back(15'b100_0_101_0_101_0_01_1);
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
         if (got !== e) begin
            n_err++; $display("FAIL priority[%0d] got=%b want=%b", i, got, e);
         end
      end
      @(negedge CLK);
      START = 1'b0;
      RESET = 1'b1;
      sb.push_back(7'b000_0_00_0);
      #1;
      got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
      if (got !== e) begin
         n_err++; $display("FAIL midrun_reset got=%b want=%b", got, e);
      end
      @(negedge CLK);
      RESET = 1'b0;
      apply(15'b001_1_000_0_001_0_00_0);
      got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
      if (got !== e) begin
         n_err++; $display("FAIL post_reset_step got=%b want=%b", got, e);
      end
   endtask

`ifdef PRESCALE_EN
   task automatic test_prescale();
      logic [14:0] t[$];
      logic [6:0]  got, e;
      t.push_back(15'b100_1_010_0_000_0_01_1);
      for (int k = 0; k < 3; k++) t.push_back(15'b000_1_010_0_000_0_01_1);
      t.push_back(15'b000_1_010_0_001_0_01_1);
      for (int k = 0; k < 3; k++) t.push_back(15'b000_1_010_0_001_0_01_1);
      t.push_back(15'b000_1_010_0_010_1_11_0);
      t.push_back(15'b000_1_010_0_010_0_00_0);
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         got = {A, B, C, DONE, STATE, BUSY}; e = sb.pop_front(); n_vec++;
         if (got !== e) begin
            n_err++; $display("FAIL prescale[%0d] got=%b want=%b", i, got, e);
         end
      end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
`ifdef PRESCALE_EN
      test_prescale();
`else
      test_basic_run();
      test_wrap();
      test_gray_len8();
      test_pause_resume();
      test_priority_and_reset();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
